// File: rtl/cae_window_feeder.sv
// cae_window_feeder: buffers three image lines from a raster stream and presents 3 x INPUT_SIZE windows to the CAE
module cae_window_feeder #(
   parameter int DATA_WIDTH = 16,
   parameter int INPUT_SIZE = 3,
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28
) (
   input  logic                             clk_i,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             pix_valid,
   input  logic [DATA_WIDTH-1:0]            pix_data,
   output logic                             pix_ready,
   output logic [INPUT_SIZE*DATA_WIDTH-1:0] data_row1_out,
   output logic [INPUT_SIZE*DATA_WIDTH-1:0] data_row2_out,
   output logic [INPUT_SIZE*DATA_WIDTH-1:0] data_row3_out,
   output logic                             enable,
   input  logic                             conv_comp,
   output logic                             busy,
   output logic                             frame_done
);
   localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int LW = $clog2(IMG_HEIGHT + 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] WIN_LAST  = CW'(IMG_WIDTH - INPUT_SIZE);
   localparam logic [LW-1:0] LINES_ALL = LW'(IMG_HEIGHT);

   typedef enum logic [2:0] {IDLE, FILL, EMIT, LOAD, DONE} state_t;

   state_t                state;
   logic [CW-1:0]         col;
   logic [LW-1:0]         lines;
   logic [1:0]            top;
   logic [1:0]            mid;
   logic [1:0]            bot;
   logic [1:0]            wr_line;
   logic                  xfer;
   logic [DATA_WIDTH-1:0] mem [3][IMG_WIDTH];

   assign xfer    = pix_valid & pix_ready;
   assign mid     = (top == 2'd2) ? 2'd0 : top + 2'd1;
   assign bot     = (top == 2'd0) ? 2'd2 : top - 2'd1;
   assign wr_line = (state == FILL) ? lines[1:0] : top;

   // line memories: FILL writes lines 0..2 in order, LOAD overwrites the oldest line
   always_ff @(posedge clk_i) begin
      if (xfer) mem[wr_line][col] <= pix_data;
   end

   // window taps: oldest/middle/newest line, columns col..col+INPUT_SIZE-1, zero when no window
   always_comb begin
      data_row1_out = '0;
      data_row2_out = '0;
      data_row3_out = '0;
      for (int k = 0; k < INPUT_SIZE; k++) begin
         data_row1_out[k*DATA_WIDTH +: DATA_WIDTH] = enable ? mem[top][col + CW'(k)] : '0;
         data_row2_out[k*DATA_WIDTH +: DATA_WIDTH] = enable ? mem[mid][col + CW'(k)] : '0;
         data_row3_out[k*DATA_WIDTH +: DATA_WIDTH] = enable ? mem[bot][col + CW'(k)] : '0;
      end
   end

   // frame sequencing with registered handshake and status outputs
   always_ff @(posedge clk_i or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         col        <= '0;
         lines      <= '0;
         top        <= '0;
         pix_ready  <= 1'b0;
         enable     <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state     <= FILL;
               col       <= '0;
               lines     <= '0;
               top       <= '0;
               pix_ready <= 1'b1;
               busy      <= 1'b1;
            end
            FILL, LOAD: if (xfer) begin
               col <= (col == COL_LAST) ? '0 : col + CW'(1);
               if (col == COL_LAST) begin
                  lines <= lines + LW'(1);
                  if (state == LOAD) top <= mid;
                  if (state == LOAD || lines == LW'(2)) begin
                     state     <= EMIT;
                     pix_ready <= 1'b0;
                     enable    <= 1'b1;
                  end
               end
            end
            EMIT: if (conv_comp) begin
               if (col < WIN_LAST) col <= col + CW'(1);
               else begin
                  col    <= '0;
                  enable <= 1'b0;
                  if (lines == LINES_ALL) begin
                     state      <= DONE;
                     frame_done <= 1'b1;
                  end else begin
                     state     <= LOAD;
                     pix_ready <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cae_window_feeder.sv
// tb_cae_window_feeder: scoreboard bench for the window feeder on a 5x4 frame
module tb_cae_window_feeder;
   localparam int DW = 16;
   localparam int IS = 3;
   localparam int W  = 5;
   localparam int H  = 4;
   localparam int RW = IS * DW;
   localparam int NWIN = (W - IS + 1) * (H - 2);

   typedef struct packed {
      logic [RW-1:0] r1;
      logic [RW-1:0] r2;
      logic [RW-1:0] r3;
   } win_t;

   logic          clk_i = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          pix_valid = 1'b0;
   logic [DW-1:0] pix_data = '0;
   logic          pix_ready;
   logic [RW-1:0] data_row1_out;
   logic [RW-1:0] data_row2_out;
   logic [RW-1:0] data_row3_out;
   logic          enable;
   logic          conv_comp = 1'b0;
   logic          busy;
   logic          frame_done;

   cae_window_feeder #(
      .DATA_WIDTH(DW),
      .INPUT_SIZE(IS),
      .IMG_WIDTH(W),
      .IMG_HEIGHT(H)
   ) dut (
      .clk_i(clk_i),
      .rst(rst),
      .start(start),
      .pix_valid(pix_valid),
      .pix_data(pix_data),
      .pix_ready(pix_ready),
      .data_row1_out(data_row1_out),
      .data_row2_out(data_row2_out),
      .data_row3_out(data_row3_out),
      .enable(enable),
      .conv_comp(conv_comp),
      .busy(busy),
      .frame_done(frame_done)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int   checks = 0;
   int   errors = 0;
   win_t exp_q[$];
   win_t got_q[$];
   logic [DW-1:0] frame [W*H];
   bit   stop = 1'b0;
   bit   fdone_seen = 1'b0;
   bit   seen_en = 1'b0;
   bit   prev_fd = 1'b0;
   int   frame_acks = 0;
   int   rdy_cnt = 0;
   int   en_low = 0;
   int   ovl = 0;
   int   last_ack = -10;

   function automatic logic [RW-1:0] pack3(input int a, input int b, input int c);
      return {DW'(c), DW'(b), DW'(a)};
   endfunction

   // monitor: pops the expected window whenever the CAE acknowledges one
   initial forever begin
      win_t g;
      win_t e;
      @(negedge clk_i);
      if (rst) begin
         if (pix_ready) rdy_cnt++;
         if (pix_ready && enable) ovl++;
         if (enable) seen_en = 1'b1;
         else if (seen_en && busy && !frame_done) en_low++;
         if (enable && conv_comp) begin
            g = '{data_row1_out, data_row2_out, data_row3_out};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL window_extra: got %h/%h/%h, required no window", g.r1, g.r2, g.r3);
            end else begin
               e = exp_q.pop_front();
               if (g != e) begin
                  errors++;
                  $display("FAIL window: got %h/%h/%h, required %h/%h/%h", g.r1, g.r2, g.r3, e.r1, e.r2, e.r3);
               end
            end
            got_q.push_back(g);
            frame_acks++;
            last_ack = cyc;
         end
         if (frame_done) begin
            checks++;
            if (exp_q.size() != 0 || cyc != last_ack + 1 || prev_fd) begin
               errors++;
               $display("FAIL frame_done: pending=%0d cycles_after_ack=%0d prev=%0b, required 0/1/0", exp_q.size(), cyc - last_ack, prev_fd);
            end
            fdone_seen = 1'b1;
         end
         prev_fd = frame_done;
      end
   end

   task automatic pix_drv(input int n, input int vmode);
      int idx = 0;
      int guard = 0;
      bit tog = 1'b1;
      logic x;
      while (idx < n && guard < 4000 && !stop) begin
         pix_data = frame[idx];
         pix_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? tog : 1'($urandom_range(0, 1));
         tog = ~tog;
         @(negedge clk_i);
         x = pix_valid & pix_ready;
         @(posedge clk_i);
         #1;
         if (x) idx++;
         guard++;
      end
      pix_valid = 1'b0;
   endtask

   task automatic conv_drv(input int cmode);
      int cnt = 0;
      int dly = 2;
      while (!stop) begin
         @(posedge clk_i);
         #1;
         if (cmode == 1) conv_comp = 1'b1;
         else if (conv_comp) begin
            conv_comp = 1'b0;
            cnt = 0;
            dly = (cmode == 2) ? int'($urandom_range(0, 3)) : 2;
         end else if (enable) begin
            cnt++;
            if (cnt > dly) conv_comp = 1'b1;
         end else if (cmode == 3 && $urandom_range(0, 3) == 0) conv_comp = 1'b1;
      end
      conv_comp = 1'b0;
   endtask

   task automatic spam_drv(input bit en);
      while (en && !stop) begin
         @(posedge clk_i);
         #1;
         start = busy && ($urandom_range(0, 4) == 0);
      end
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!fdone_seen && n < 3000) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      checks++;
      if (!fdone_seen) begin
         errors++;
         $display("FAIL frame_timeout: frame_done absent after %0d cycles, required within 3000", n);
      end
      stop = 1'b1;
   endtask

   task automatic run_frame(input int dmode, input int vmode, input int cmode, input bit spam);
      for (int i = 0; i < W*H; i++) frame[i] = (dmode == 0) ? DW'(i) : DW'($urandom);
      for (int r = 0; r < H - 2; r++) begin
         for (int c = 0; c <= W - IS; c++) begin
            win_t w;
            for (int k = 0; k < IS; k++) begin
               w.r1[k*DW +: DW] = frame[r*W + c + k];
               w.r2[k*DW +: DW] = frame[(r+1)*W + c + k];
               w.r3[k*DW +: DW] = frame[(r+2)*W + c + k];
            end
            exp_q.push_back(w);
         end
      end
      got_q.delete();
      stop = 1'b0;
      fdone_seen = 1'b0;
      seen_en = 1'b0;
      frame_acks = 0;
      rdy_cnt = 0;
      en_low = 0;
      ovl = 0;
      @(posedge clk_i);
      #1 start = 1'b1;
      @(posedge clk_i);
      #1 start = 1'b0;
      fork
         pix_drv(W*H, vmode);
         conv_drv(cmode);
         spam_drv(spam);
         wait_done();
      join
      checks++;
      if (frame_acks != NWIN) begin
         errors++;
         $display("FAIL window_count: got %0d, required %0d", frame_acks, NWIN);
      end
      checks++;
      if (ovl != 0) begin
         errors++;
         $display("FAIL ready_enable_overlap: got %0d cycles, required 0", ovl);
      end
      if (vmode == 0) begin
         checks++;
         if (rdy_cnt != W*H) begin
            errors++;
            $display("FAIL ready_cycles: got %0d, required %0d", rdy_cnt, W*H);
         end
      end
      if (cmode == 1) begin
         checks++;
         if (en_low != (H-3)*W) begin
            errors++;
            $display("FAIL enable_low_cycles: got %0d, required %0d", en_low, (H-3)*W);
         end
      end
      checks++;
      if (busy || frame_done || pix_ready || enable) begin
         errors++;
         $display("FAIL idle_after_frame: busy=%0b done=%0b ready=%0b en=%0b, required 0000", busy, frame_done, pix_ready, enable);
      end
      if (!fdone_seen) begin
         rst = 1'b0;
         repeat (2) @(posedge clk_i);
         #1 rst = 1'b1;
         exp_q.delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(posedge clk_i);
      #1;
      checks++;
      if (pix_ready || enable || busy || frame_done || data_row1_out != '0 || data_row2_out != '0 || data_row3_out != '0) begin
         errors++;
         $display("FAIL reset_state: ready=%0b en=%0b busy=%0b done=%0b, required all zero", pix_ready, enable, busy, frame_done);
      end
      rst = 1'b1;

      run_frame(0, 0, 0, 1'b0);
      checks++;
      if (got_q.size() < 4) begin
         errors++;
         $display("FAIL directed_windows: got %0d windows, required at least 4", got_q.size());
      end else begin
         if (got_q[0] != '{pack3(0, 1, 2), pack3(5, 6, 7), pack3(10, 11, 12)}) begin
            errors++;
            $display("FAIL first_window: got %h/%h/%h, required {0,1,2}/{5,6,7}/{10,11,12}", got_q[0].r1, got_q[0].r2, got_q[0].r3);
         end
         checks++;
         if (got_q[3] != '{pack3(5, 6, 7), pack3(10, 11, 12), pack3(15, 16, 17)}) begin
            errors++;
            $display("FAIL fourth_window: got %h/%h/%h, required {5,6,7}/{10,11,12}/{15,16,17}", got_q[3].r1, got_q[3].r2, got_q[3].r3);
         end
      end

      run_frame(0, 1, 0, 1'b0);
      run_frame(0, 0, 1, 1'b0);
      run_frame(0, 0, 3, 1'b1);

      for (int i = 0; i < W*H; i++) frame[i] = DW'(i);
      stop = 1'b0;
      @(posedge clk_i);
      #1 start = 1'b1;
      @(posedge clk_i);
      #1 start = 1'b0;
      pix_drv(3*W, 0);
      n = 0;
      while (!enable && n < 20) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      checks++;
      if (!enable) begin
         errors++;
         $display("FAIL abort_emit_entry: enable=%0b, required 1", enable);
      end
      @(posedge clk_i);
      #1 rst = 1'b0;
      #1;
      checks++;
      if (enable || busy || pix_ready || frame_done || data_row1_out != '0 || data_row2_out != '0 || data_row3_out != '0) begin
         errors++;
         $display("FAIL abort_reset: en=%0b busy=%0b ready=%0b row1=%h, required all zero", enable, busy, pix_ready, data_row1_out);
      end
      repeat (2) @(posedge clk_i);
      #1 rst = 1'b1;
      run_frame(0, 0, 0, 1'b0);

      repeat (4) run_frame(1, 2, 2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
